// File: rtl/operand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_pkg
// Purpose  : Shared encodings for the operand loader (FSM states, bank slots).
// Revision : 1.0 - initial release
// ============================================================================
package operand_pkg;

  localparam logic       ST_LOAD = 1'b0;
  localparam logic       ST_FULL = 1'b1;

  localparam logic [1:0] OP_A = 2'b00;
  localparam logic [1:0] OP_B = 2'b01;
  localparam logic [1:0] OP_C = 2'b10;
  localparam logic [1:0] OP_D = 2'b11;

  localparam int         NUM_OPS      = 4;
  localparam logic [2:0] C_COUNT_FULL = 3'd4;

  // Word count reported on op_count for a given state/slot pair.
  function automatic logic [2:0] words_held(input logic state, input logic [1:0] idx);
    return (state == ST_FULL) ? C_COUNT_FULL : {1'b0, idx};
  endfunction

endpackage : operand_pkg
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// ============================================================================
// Module   : operand_bank
// Purpose  : Four operand registers (A..D) with indexed write, async clear.
// Revision : 1.0 - initial release
// ============================================================================
module operand_bank
  import operand_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d
);

  logic [WIDTH-1:0] r_bank [NUM_OPS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (wr_en) begin
      r_bank[wr_idx] <= wr_data;
    end
  end

  assign out_a = r_bank[OP_A];
  assign out_b = r_bank[OP_B];
  assign out_c = r_bank[OP_C];
  assign out_d = r_bank[OP_D];

endmodule : operand_bank
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : operand_loader
// Purpose  : Assembles a serial word stream into an A..D operand bundle and
//            hands it off on a valid/ready handshake; counts delivered bundles.
// Revision : 1.0 - initial release
// ============================================================================
module operand_loader
  import operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [2:0]       op_count,
  output logic [CNT_W-1:0] bundle_count
);

  logic             r_state;
  logic             w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [2:0]       r_op_count;
  logic [CNT_W-1:0] r_bundle_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_handoff;
  logic [1:0]       w_bank_idx;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and slot index; flush overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (flush) begin
      w_state_nxt = ST_LOAD;
      w_idx_nxt   = OP_A;
    end else if (r_state == ST_LOAD) begin
      if (w_accept) begin
        if (r_idx == OP_D) begin
          w_state_nxt = ST_FULL;
          w_idx_nxt   = OP_A;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
        end
      end
    end else if (out_ready) begin
      // A word taken during hand-off already occupies slot A of the next bundle.
      w_state_nxt = ST_LOAD;
      w_idx_nxt   = w_accept ? OP_B : OP_A;
    end
  end

  // Outputs of the FSM: handshake and bank write steering.
  always_comb begin
    w_in_ready = 1'b0;
    if (reset && !flush) begin
      if (r_state == ST_LOAD) begin
        w_in_ready = 1'b1;
      end else begin
        w_in_ready = out_ready;
      end
    end
    w_accept   = in_valid & w_in_ready;
    w_handoff  = (r_state == ST_FULL) & out_ready & ~flush;
    w_bank_idx = (r_state == ST_FULL) ? OP_A : r_idx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx      <= OP_A;
      r_op_count <= 3'd0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_op_count <= words_held(w_state_nxt, w_idx_nxt);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bundle_count <= '0;
    end else if (w_handoff) begin
      r_bundle_count <= r_bundle_count + 1'b1;
    end
  end

  operand_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_accept),
    .wr_idx  (w_bank_idx),
    .wr_data (in_data),
    .out_a   (out_a),
    .out_b   (out_b),
    .out_c   (out_c),
    .out_d   (out_d)
  );

  assign in_ready     = w_in_ready;
  assign out_valid    = (r_state == ST_FULL);
  assign op_count     = r_op_count;
  assign bundle_count = r_bundle_count;

endmodule : operand_loader
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_loader
// Purpose  : Directed self-checking bench for operand_loader (default and
//            2-bit bundle counter instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready,   out_valid;
  logic [31:0] out_a, out_b, out_c, out_d;
  logic [2:0]  op_count;
  logic [15:0] bundle_count;

  logic        in_ready_w, out_valid_w;
  logic [31:0] out_a_w, out_b_w, out_c_w, out_d_w;
  logic [2:0]  op_count_w;
  logic [1:0]  bundle_count_w;

  int n_pass  = 0;
  int n_check = 0;

  operand_loader #(.WIDTH(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .op_count(op_count), .bundle_count(bundle_count)
  );

  operand_loader #(.WIDTH(32), .CNT_W(2)) dut_w (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w), .flush(flush), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_a(out_a_w), .out_b(out_b_w), .out_c(out_c_w), .out_d(out_d_w),
    .op_count(op_count_w), .bundle_count(bundle_count_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  logic [1:0] wrap_seq [5];

  initial begin
    wrap_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // 1. reset asserted mid-load
    repeat (2) tick();
    reset = 1'b1;
    feed(32'h11);
    feed(32'h22);
    chk("partial_count", op_count, 3'd2);
    chk("partial_a", out_a, 32'h11);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_state", {out_valid, op_count, bundle_count}, {1'b0, 3'd0, 16'd0});
    chk("rst_bank", {out_a, out_b, out_c, out_d}, 128'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // 2. load 1..4 with the consumer stalled
    feed(32'd1);
    feed(32'd2);
    feed(32'd3);
    chk("three_held", {out_valid, op_count}, {1'b0, 3'd3});
    feed(32'd4);
    chk("full_valid", {out_valid, op_count}, {1'b1, 3'd4});
    chk("full_bundle", {out_a, out_b, out_c, out_d}, {32'd1, 32'd2, 32'd3, 32'd4});
    in_valid = 1'b1;
    in_data  = 32'h99;
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", {out_valid, out_a, out_b, out_c, out_d},
          {1'b1, 32'd1, 32'd2, 32'd3, 32'd4});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("handoff_idle", {out_valid, op_count, bundle_count}, {1'b0, 3'd0, 16'd1});

    // 3. continuous stream with the consumer always ready
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      #1;
      if (i == 5) chk("handoff_in_ready", in_ready, 1'b1);
      tick();
      if (i == 4) chk("stream_b1", {out_valid, out_a, out_b, out_c, out_d},
                      {1'b1, 32'd1, 32'd2, 32'd3, 32'd4});
      if (i == 5) chk("handoff_accept", {out_valid, op_count, out_a, bundle_count},
                      {1'b0, 3'd1, 32'd5, 16'd2});
    end
    in_valid = 1'b0;
    chk("stream_b2", {out_valid, out_a, out_b, out_c, out_d},
        {1'b1, 32'd5, 32'd6, 32'd7, 32'd8});
    tick();
    chk("stream_count", {out_valid, bundle_count}, {1'b0, 16'd3});

    // 4. flush a partial bundle, then reload
    out_ready = 1'b0;
    feed(32'hA);
    feed(32'hB);
    chk("pre_flush_count", op_count, 3'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hC;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", {out_valid, op_count}, {1'b0, 3'd0});
    chk("flush_retain", {out_a, out_b, out_c}, {32'hA, 32'hB, 32'd7});
    feed(32'd5);
    feed(32'd6);
    feed(32'd7);
    feed(32'd8);
    chk("reload_bundle", {out_valid, out_a, out_b, out_c, out_d},
        {1'b1, 32'd5, 32'd6, 32'd7, 32'd8});

    // 5. flush wins over hand-off
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_full", {out_valid, op_count, bundle_count}, {1'b0, 3'd0, 16'd3});

    // 6. counter wrap on the 2-bit instance
    reset = 1'b0;
    #1;
    chk("wrap_rst", {bundle_count, bundle_count_w}, {16'd0, 2'd0});
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int k = 1; k <= 4; k++) feed(32'((b + 4) * 16 + k));
      chk("wrap_full", out_valid_w, 1'b1);
      tick();
      chk("wrap_seq", bundle_count_w, wrap_seq[b]);
      chk("wide_seq", bundle_count, 16'(b + 1));
    end
    chk("wrap_tail", {out_valid_w, op_count_w, in_ready_w}, {1'b0, 3'd0, 1'b1});
    chk("wrap_bank", {out_a_w, out_b_w, out_c_w, out_d_w},
        {32'h81, 32'h82, 32'h83, 32'h84});

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule : tb_operand_loader
`default_nettype wire
